branch_unit: RTL and testbench

BRANCH_UNIT -- requirements
Module: branch_unit

---
 rtl/branch_unit.sv | 162 ++++++++++++++++
 tb/tb_branch_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_unit.sv
// ============================================================================
// Module   : branch_unit
// Purpose  : Conditional branch resolver. Holds a {Z,C,S,O} flag register,
//            evaluates a 4-bit condition code on each accepted request, and
//            emits a one-cycle redirect pulse with the next fetch address.
//            A taken branch costs one FLUSH cycle during which requests are
//            refused. A saturating counter tracks taken branches.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_unit #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned BYPASS = 1
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              flag_we,
  input  logic              zero_in,
  input  logic              carry_in,
  input  logic              sign_in,
  input  logic              overflow_in,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [3:0]        br_cond,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] br_target,
  output logic              redirect_valid,
  output logic              redirect_taken,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              illegal_cond,
  output logic [CNT_W-1:0]  taken_count
);

  localparam bit            BYP_EN  = (BYPASS != 0);
  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_READY = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e              state_q;
  logic                br_ready_q;
  logic [3:0]          flags_q;          // {Z,C,S,O}
  logic                redirect_valid_q;
  logic                redirect_taken_q;
  logic [ADDR_W-1:0]   redirect_pc_q;
  logic                illegal_q;
  logic [CNT_W-1:0]    taken_count_q;

  logic                accept;
  logic                z_e, c_e, s_e, o_e;
  logic                taken_d;
  logic                illegal_d;
  logic [ADDR_W-1:0]   redirect_pc_d;

  assign accept = br_valid & br_ready_q;

  // Pick evaluation flags (forwarded ALU flags or stored copy) and resolve the condition.
  always_comb begin
    z_e       = flags_q[3];
    c_e       = flags_q[2];
    s_e       = flags_q[1];
    o_e       = flags_q[0];
    taken_d   = 1'b0;
    illegal_d = 1'b0;
    if (BYP_EN && flag_we) begin
      z_e = zero_in;
      c_e = carry_in;
      s_e = sign_in;
      o_e = overflow_in;
    end
    case (br_cond)
      4'd0:    taken_d = 1'b0;
      4'd1:    taken_d = 1'b1;
      4'd2:    taken_d = z_e;
      4'd3:    taken_d = ~z_e;
      4'd4:    taken_d = c_e;
      4'd5:    taken_d = c_e | z_e;
      4'd6:    taken_d = ~c_e & ~z_e;
      4'd7:    taken_d = ~c_e;
      4'd8:    taken_d = ~z_e & (s_e == o_e);
      4'd9:    taken_d = (s_e == o_e);
      4'd10:   taken_d = (s_e != o_e);
      4'd11:   taken_d = z_e | (s_e != o_e);
      default: illegal_d = 1'b1;     // reserved codes resolve not-taken
    endcase
    redirect_pc_d = taken_d ? br_target : (br_pc + PC_ONE);
  end

  // Flag register loads the ALU flags whenever flag_we is high.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      flags_q <= 4'b0000;
    end else if (flag_we) begin
      flags_q <= {zero_in, carry_in, sign_in, overflow_in};
    end
  end

  // READY/FLUSH control: a taken accept inserts exactly one refusal cycle.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= ST_READY;
      br_ready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_READY: begin
          if (accept && taken_d) begin
            state_q    <= ST_FLUSH;
            br_ready_q <= 1'b0;
          end
        end
        ST_FLUSH: begin
          state_q    <= ST_READY;
          br_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= ST_READY;
          br_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Result registers: pulse outputs follow accept, decision/address hold between pulses.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      redirect_valid_q <= 1'b0;
      redirect_taken_q <= 1'b0;
      redirect_pc_q    <= '0;
      illegal_q        <= 1'b0;
    end else begin
      redirect_valid_q <= accept;
      illegal_q        <= accept & illegal_d;
      if (accept) begin
        redirect_taken_q <= taken_d;
        redirect_pc_q    <= redirect_pc_d;
      end
    end
  end

  // Taken-branch statistics, saturating at all-ones.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      taken_count_q <= '0;
    end else if (accept && taken_d && (taken_count_q != {CNT_W{1'b1}})) begin
      taken_count_q <= taken_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign br_ready       = br_ready_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_taken = redirect_taken_q;
  assign redirect_pc    = redirect_pc_q;
  assign illegal_cond   = illegal_q;
  assign taken_count    = taken_count_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_unit.sv
// ============================================================================
// Module   : tb_branch_unit
// Purpose  : Self-checking bench for branch_unit. Two instances share the
//            stimulus: A uses defaults (BYPASS=1, CNT_W=8), B uses BYPASS=0,
//            CNT_W=2. A behavioural model predicts every output.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_branch_unit;

  logic        clk;
  logic        n_reset;
  logic        flag_we, zero_in, carry_in, sign_in, overflow_in;
  logic        br_valid;
  logic [3:0]  br_cond;
  logic [15:0] br_pc, br_target;

  logic        a_ready, a_rv, a_tk, a_ill;
  logic [15:0] a_pc;
  logic [7:0]  a_cnt;
  logic        b_ready, b_rv, b_tk, b_ill;
  logic [15:0] b_pc;
  logic [1:0]  b_cnt;

  logic [19:0] obs_a, obs_b;
  assign obs_a = {a_ready, a_rv, a_tk, a_ill, a_pc};
  assign obs_b = {b_ready, b_rv, b_tk, b_ill, b_pc};

  int n_checks = 0;
  int n_pass   = 0;

  branch_unit dut_a (
    .clk(clk), .n_reset(n_reset), .flag_we(flag_we),
    .zero_in(zero_in), .carry_in(carry_in), .sign_in(sign_in), .overflow_in(overflow_in),
    .br_valid(br_valid), .br_ready(a_ready), .br_cond(br_cond),
    .br_pc(br_pc), .br_target(br_target),
    .redirect_valid(a_rv), .redirect_taken(a_tk), .redirect_pc(a_pc),
    .illegal_cond(a_ill), .taken_count(a_cnt)
  );

  branch_unit #(.ADDR_W(16), .CNT_W(2), .BYPASS(0)) dut_b (
    .clk(clk), .n_reset(n_reset), .flag_we(flag_we),
    .zero_in(zero_in), .carry_in(carry_in), .sign_in(sign_in), .overflow_in(overflow_in),
    .br_valid(br_valid), .br_ready(b_ready), .br_cond(br_cond),
    .br_pc(br_pc), .br_target(br_target),
    .redirect_valid(b_rv), .redirect_taken(b_tk), .redirect_pc(b_pc),
    .illegal_cond(b_ill), .taken_count(b_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  logic [3:0]  m_flags [2];
  bit          m_ready [2];
  bit          m_rv    [2];
  bit          m_tk    [2];
  bit          m_ill   [2];
  logic [15:0] m_pc    [2];
  int          m_cnt   [2];
  int          cnt_max [2] = '{255, 3};
  bit          byp     [2] = '{1'b1, 1'b0};

  function automatic bit cond_true(input logic [3:0] code, input logic [3:0] f);
    bit z, c, s, o;
    z = f[3]; c = f[2]; s = f[1]; o = f[0];
    case (code)
      4'd1:    return 1'b1;
      4'd2:    return z;
      4'd3:    return !z;
      4'd4:    return c;
      4'd5:    return c || z;
      4'd6:    return !c && !z;
      4'd7:    return !c;
      4'd8:    return !z && (s == o);
      4'd9:    return s == o;
      4'd10:   return s != o;
      4'd11:   return z || (s != o);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_flags[k] = 4'b0; m_ready[k] = 1'b1; m_rv[k] = 1'b0;
      m_tk[k] = 1'b0; m_ill[k] = 1'b0; m_pc[k] = 16'h0; m_cnt[k] = 0;
    end
  endtask

  task automatic model_edge();
    logic [3:0] fin, fe;
    bit acc, tk, ill;
    if (!n_reset) begin
      model_reset();
      return;
    end
    fin = {zero_in, carry_in, sign_in, overflow_in};
    for (int k = 0; k < 2; k++) begin
      acc = br_valid && m_ready[k];
      fe  = (byp[k] && flag_we) ? fin : m_flags[k];
      tk  = 1'b0;
      if (acc) begin
        ill = (br_cond >= 4'd12);
        tk  = !ill && cond_true(br_cond, fe);
        m_rv[k]  = 1'b1;
        m_tk[k]  = tk;
        m_ill[k] = ill;
        m_pc[k]  = tk ? br_target : 16'((32'(br_pc) + 1) % 65536);
        if (tk && m_cnt[k] < cnt_max[k]) m_cnt[k]++;
      end else begin
        m_rv[k]  = 1'b0;
        m_ill[k] = 1'b0;
      end
      m_ready[k] = !(acc && tk);
      if (flag_we) m_flags[k] = fin;
    end
  endtask

  function automatic logic [19:0] exp_vec(input int k);
    return {m_ready[k], m_rv[k], m_tk[k], m_ill[k], m_pc[k]};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    flag_we = 0; zero_in = 0; carry_in = 0; sign_in = 0; overflow_in = 0;
    br_valid = 0; br_cond = 4'd0; br_pc = 16'h0; br_target = 16'h0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    n_reset = 1'b1;
    #1 n_reset = 1'b0;
    model_reset();
    #2;
    n_checks++; if (obs_a !== 20'h80000) $display("FAIL reset_a got %h exp %h", obs_a, 20'h80000); else n_pass++;
    n_checks++; if (obs_b !== 20'h80000) $display("FAIL reset_b got %h exp %h", obs_b, 20'h80000); else n_pass++;
    n_checks++; if (a_cnt !== 8'd0 || b_cnt !== 2'd0) $display("FAIL reset_cnt got %h/%h exp 0/0", a_cnt, b_cnt); else n_pass++;
    @(negedge clk); n_reset = 1'b1;
    tick();
    n_checks++; if (obs_a !== 20'h80000) $display("FAIL post_reset_idle got %h exp %h", obs_a, 20'h80000); else n_pass++;
  endtask

  task automatic test_jz_taken();
    @(negedge clk); idle_inputs(); flag_we = 1; zero_in = 1;
    tick();
    @(negedge clk); idle_inputs(); br_valid = 1; br_cond = 4'd2; br_pc = 16'h0010; br_target = 16'h0200;
    tick();
    n_checks++; if (obs_a !== {4'b0110, 16'h0200}) $display("FAIL jz_a got %h exp %h", obs_a, {4'b0110, 16'h0200}); else n_pass++;
    n_checks++; if (obs_b !== {4'b0110, 16'h0200}) $display("FAIL jz_b got %h exp %h", obs_b, {4'b0110, 16'h0200}); else n_pass++;
    @(negedge clk); br_valid = 0;
    tick();
    n_checks++; if (obs_a !== {4'b1010, 16'h0200}) $display("FAIL jz_flush_end got %h exp %h", obs_a, {4'b1010, 16'h0200}); else n_pass++;
  endtask

  task automatic test_signed_conds();
    logic [3:0] conds [5] = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd11};
    bit exp_rv [5] = '{1, 1, 1, 0, 1};
    bit exp_tk [5] = '{0, 0, 1, 1, 1};
    bit exp_rd [5] = '{1, 1, 0, 1, 0};
    @(negedge clk); idle_inputs(); flag_we = 1; sign_in = 1;
    tick();
    for (int j = 0; j < 5; j++) begin
      @(negedge clk); idle_inputs(); br_valid = 1; br_cond = conds[j];
      br_pc = 16'h0100 + 16'(j); br_target = 16'h0800 + 16'(j);
      tick();
      n_checks++;
      if (a_rv !== exp_rv[j] || a_tk !== exp_tk[j] || a_ready !== exp_rd[j])
        $display("FAIL signed_cond step %0d got rv/tk/rdy %b%b%b exp %b%b%b", j, a_rv, a_tk, a_ready, exp_rv[j], exp_tk[j], exp_rd[j]);
      else n_pass++;
      n_checks++; if (obs_b !== exp_vec(1)) $display("FAIL signed_cond_b step %0d got %h exp %h", j, obs_b, exp_vec(1)); else n_pass++;
    end
    @(negedge clk); idle_inputs();
    tick();
  endtask

  task automatic test_bypass();
    @(negedge clk); idle_inputs(); flag_we = 1;
    tick();
    @(negedge clk); idle_inputs(); flag_we = 1; carry_in = 1;
    br_valid = 1; br_cond = 4'd4; br_pc = 16'h1234; br_target = 16'h4000;
    tick();
    n_checks++; if (obs_a !== {4'b0110, 16'h4000}) $display("FAIL bypass_on got %h exp %h", obs_a, {4'b0110, 16'h4000}); else n_pass++;
    n_checks++; if (obs_b !== {4'b1100, 16'h1235}) $display("FAIL bypass_off got %h exp %h", obs_b, {4'b1100, 16'h1235}); else n_pass++;
    @(negedge clk); idle_inputs();
    tick();
    @(negedge clk); idle_inputs(); br_valid = 1; br_cond = 4'd4; br_pc = 16'h2000; br_target = 16'h3000;
    tick();
    n_checks++; if (obs_b !== {4'b0110, 16'h3000}) $display("FAIL bypass_off_stored got %h exp %h", obs_b, {4'b0110, 16'h3000}); else n_pass++;
    @(negedge clk); idle_inputs();
    tick();
  endtask

  task automatic test_wrap_illegal();
    @(negedge clk); idle_inputs(); br_valid = 1; br_cond = 4'd0; br_pc = 16'hFFFF; br_target = 16'h1111;
    tick();
    n_checks++; if (obs_a !== {4'b1100, 16'h0000}) $display("FAIL pc_wrap got %h exp %h", obs_a, {4'b1100, 16'h0000}); else n_pass++;
    @(negedge clk); br_cond = 4'd13; br_pc = 16'h0042; br_target = 16'h0999;
    tick();
    n_checks++; if (obs_a !== {4'b1101, 16'h0043}) $display("FAIL illegal got %h exp %h", obs_a, {4'b1101, 16'h0043}); else n_pass++;
    n_checks++; if (b_ill !== 1'b1) $display("FAIL illegal_b got %b exp 1", b_ill); else n_pass++;
    @(negedge clk); idle_inputs();
    tick();
    n_checks++; if (a_ill !== 1'b0 || a_rv !== 1'b0) $display("FAIL illegal_pulse_end got ill/rv %b%b exp 00", a_ill, a_rv); else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 8; j++) begin
      @(negedge clk); idle_inputs(); br_valid = 1; br_cond = 4'd0;
      br_pc = 16'h0500 + 16'(j * 3); br_target = 16'h7777;
      tick();
      n_checks++;
      if (obs_a !== {4'b1100, 16'h0501 + 16'(j * 3)})
        $display("FAIL back_to_back %0d got %h exp %h", j, obs_a, {4'b1100, 16'h0501 + 16'(j * 3)});
      else n_pass++;
    end
    @(negedge clk); idle_inputs();
    tick();
  endtask

  task automatic test_saturation();
    @(negedge clk); idle_inputs(); n_reset = 0;
    model_reset();
    @(negedge clk); n_reset = 1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk); idle_inputs(); br_valid = 1; br_cond = 4'd1;
      br_pc = 16'($urandom); br_target = 16'($urandom);
      tick();
      @(negedge clk); br_valid = 0;
      tick();
      if (j == 1) begin
        n_checks++; if (b_cnt !== 2'd2) $display("FAIL count_mid got %0d exp 2", b_cnt); else n_pass++;
      end
    end
    n_checks++; if (b_cnt !== 2'd3) $display("FAIL count_sat got %0d exp 3", b_cnt); else n_pass++;
    n_checks++; if (a_cnt !== 8'd5) $display("FAIL count_wide got %0d exp 5", a_cnt); else n_pass++;
  endtask

  task automatic test_random();
    for (int j = 0; j < 400; j++) begin
      @(negedge clk);
      flag_we     = ($urandom_range(0, 3) == 0);
      zero_in     = 1'($urandom); carry_in = 1'($urandom);
      sign_in     = 1'($urandom); overflow_in = 1'($urandom);
      br_valid    = ($urandom_range(0, 9) < 7);
      br_cond     = 4'($urandom_range(0, 15));
      br_pc       = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      br_target   = 16'($urandom);
      tick();
      n_checks++; if (obs_a !== exp_vec(0)) $display("FAIL random_a cyc %0d got %h exp %h", j, obs_a, exp_vec(0)); else n_pass++;
      n_checks++; if (obs_b !== exp_vec(1)) $display("FAIL random_b cyc %0d got %h exp %h", j, obs_b, exp_vec(1)); else n_pass++;
      n_checks++;
      if (a_cnt !== 8'(m_cnt[0]) || b_cnt !== 2'(m_cnt[1]))
        $display("FAIL random_cnt cyc %0d got %0d/%0d exp %0d/%0d", j, a_cnt, b_cnt, m_cnt[0], m_cnt[1]);
      else n_pass++;
    end
    @(negedge clk); idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    @(negedge clk); idle_inputs(); br_valid = 1; br_cond = 4'd1; br_pc = 16'h0001; br_target = 16'hABCD;
    tick();
    n_checks++; if (a_ready !== 1'b0 || a_rv !== 1'b1) $display("FAIL pre_reset_flush got rdy/rv %b%b exp 01", a_ready, a_rv); else n_pass++;
    n_reset = 1'b0;
    model_reset();
    #1;
    n_checks++; if (obs_a !== 20'h80000) $display("FAIL async_reset_a got %h exp %h", obs_a, 20'h80000); else n_pass++;
    n_checks++; if (obs_b !== 20'h80000 || b_cnt !== 2'd0 || a_cnt !== 8'd0) $display("FAIL async_reset_b got %h exp %h", obs_b, 20'h80000); else n_pass++;
    @(negedge clk); idle_inputs();
    tick();
    @(negedge clk); n_reset = 1'b1;
    tick();
    n_checks++; if (obs_a !== 20'h80000) $display("FAIL reset_release got %h exp %h", obs_a, 20'h80000); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_jz_taken();
    test_signed_conds();
    test_bypass();
    test_wrap_illegal();
    test_back_to_back();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
